// File: rtl/ariane_pkg.sv
// Minimal slice of the core-wide package: the branch-resolution record that the
// branch unit produces and the predictor consumes, plus its control-flow type.
//   cf_t          : kind of control-flow instruction that resolved
//   bp_resolve_t  : one resolution (valid, pc, target, mispredict, taken, type)
package ariane_pkg;

    localparam int unsigned VLEN = 64;

    typedef enum logic [2:0] {
        NoCF   = 3'd0,
        Branch = 3'd1,
        Jump   = 3'd2,
        JumpR  = 3'd3,
        Return = 3'd4
    } cf_t;

    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic [VLEN-1:0] target_address;
        logic            is_mispredict;
        logic            is_taken;
        cf_t             cf_type;
    } bp_resolve_t;

endpackage

// File: rtl/bp_update_sched_pkg.sv
// Shared constants and helpers for the predictor-update scheduler.
//   DROP_CNT_W : width of the overflow drop counter
//   sat_inc    : increment that sticks at all-ones
package bp_update_sched_pkg;

    localparam int unsigned DROP_CNT_W = 16;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// In-order queue of branch resolutions waiting to train the predictor.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset (clears pointers/count)
//   push_i/data_i: write data_i at the tail (caller guarantees room)
//   pop_i        : drop the head entry (caller guarantees non-empty)
//   full_o       : count == DEPTH
//   empty_o      : count == 0
//   count_o      : number of stored entries
//   head_o       : oldest entry (raw storage, meaningless when empty)
module bp_update_fifo
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  bp_resolve_t                  data_i,
    input  logic                         pop_i,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output bp_resolve_t                  head_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    bp_resolve_t      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push_i) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (pop_i) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the count alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    assign head_o  = r_mem[r_rd_ptr];
    assign count_o = r_count;
    assign full_o  = (r_count == FULL_CNT);
    assign empty_o = (r_count == '0);

endmodule

// File: rtl/bp_update_sched.sv
// Buffers branch resolutions and releases them in order to the predictor's
// update port. After an accepted mispredict, further resolutions are wrong-path
// and are ignored until the frontend signals the redirect is done (flush_i).
// Ports:
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   debug_mode_i        : suppress training except for mispredicts
//   flush_i             : redirect complete, leave the squash window
//   resolved_branch_i   : incoming resolution (.valid qualifies)
//   upd_o, upd_valid_o  : head entry toward the predictor
//   upd_ready_i         : predictor accepts upd_o this cycle
//   full_o              : queue holds DEPTH entries
//   drop_cnt_o          : saturating count of eligible resolutions lost to overflow
//   dbg_state_o         : current FSM state (0 = RUN, 1 = SQUASH)
//
// Handshake: an entry transfers on every rising edge where upd_valid_o and
// upd_ready_i are both high; while upd_valid_o is high and upd_ready_i is low
// upd_o holds steady; upd_ready_i carries no meaning while upd_valid_o is low.
module bp_update_sched
    import ariane_pkg::*;
    import bp_update_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  debug_mode_i,
    input  logic                  flush_i,
    input  bp_resolve_t           resolved_branch_i,
    output bp_resolve_t           upd_o,
    output logic                  upd_valid_o,
    input  logic                  upd_ready_i,
    output logic                  full_o,
    output logic [DROP_CNT_W-1:0] drop_cnt_o,
    output logic                  dbg_state_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_e;

    state_e                r_state;
    state_e                w_state_nxt;
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [CNT_W-1:0]      w_count;
    bp_resolve_t           w_head;

    logic                  w_upd_valid;
    logic                  w_pop;
    logic                  w_room;
    logic                  w_eligible;
    logic                  w_push;
    logic                  w_drop;

    bp_update_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_push),
        .data_i  (resolved_branch_i),
        .pop_i   (w_pop),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty),
        .count_o (w_count),
        .head_o  (w_head)
    );

    assign w_upd_valid = !w_fifo_empty;
    assign w_pop       = w_upd_valid && upd_ready_i;
    // A full queue still has room if the head leaves in the same cycle.
    assign w_room      = (w_count != FULL_CNT) || w_pop;
    // In debug mode only mispredicts still matter: they redirect the frontend.
    assign w_eligible  = resolved_branch_i.valid &&
                         (!debug_mode_i || resolved_branch_i.is_mispredict);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            RUN: begin
                // flush_i has nothing to end here, so it is not looked at.
                if (w_eligible) begin
                    if (w_room) begin
                        w_push = 1'b1;
                        if (resolved_branch_i.is_mispredict) begin
                            w_state_nxt = SQUASH;
                        end
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end
            SQUASH: begin
                // Everything arriving now is wrong-path: neither queued nor counted.
                if (flush_i) begin
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_drop_cnt <= sat_inc(r_drop_cnt);
        end
    end

    // Output is zero whenever the queue is empty so stale storage never leaks.
    always_comb begin
        upd_o = '0;
        if (w_upd_valid) begin
            upd_o       = w_head;
            upd_o.valid = 1'b1;
        end
    end

    assign upd_valid_o = w_upd_valid;
    assign full_o      = w_fifo_full;
    assign drop_cnt_o  = r_drop_cnt;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_bp_update_sched.sv
module tb_bp_update_sched;
    import ariane_pkg::*;

    localparam int unsigned W = $bits(bp_resolve_t);

    logic        clk;
    logic        rst;
    logic        debug_mode;
    logic        flush;
    bp_resolve_t rb;
    bp_resolve_t upd;
    logic        upd_valid;
    logic        upd_ready;
    logic        full;
    logic [15:0] drop_cnt;
    logic        dbg_state;

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    bp_update_sched #(
        .DEPTH (4)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .debug_mode_i      (debug_mode),
        .flush_i           (flush),
        .resolved_branch_i (rb),
        .upd_o             (upd),
        .upd_valid_o       (upd_valid),
        .upd_ready_i       (upd_ready),
        .full_o            (full),
        .drop_cnt_o        (drop_cnt),
        .dbg_state_o       (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver helpers ----------------
    function automatic bp_resolve_t mk(input logic [7:0] id, input logic mis);
        bp_resolve_t r;
        r                = '0;
        r.valid          = 1'b1;
        r.pc             = 64'h1000 + 64'(id);
        r.target_address = 64'h8000_0000 + 64'(id);
        r.is_mispredict  = mis;
        r.is_taken       = 1'b1;
        r.cf_type        = Branch;
        return r;
    endfunction

    // Advance one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- checkers ----------------
    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_e(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst        = 1'b1;
        debug_mode = 1'b0;
        flush      = 1'b0;
        upd_ready  = 1'b0;
        rb         = '0;

        // Reset state
        step();
        step();
        chk_b("rst_valid", upd_valid, 1'b0);
        chk_b("rst_full",  full,      1'b0);
        chk_w("rst_drop",  drop_cnt,  16'h0);
        chk_e("rst_upd",   upd,       '0);
        chk_b("rst_state", dbg_state, 1'b0);
        rst = 1'b0;
        step();

        // Three entries with ready high: one per cycle, in order, no bypass
        upd_ready = 1'b1;
        rb = mk(8'd1, 1'b0);
        chk_b("t1_nobypass", upd_valid, 1'b0);
        step();
        chk_b("t1_valid", upd_valid, 1'b1);
        chk_e("t1_e1", upd, mk(8'd1, 1'b0));
        rb = mk(8'd2, 1'b0);
        step();
        chk_e("t1_e2", upd, mk(8'd2, 1'b0));
        rb = mk(8'd3, 1'b0);
        step();
        chk_e("t1_e3", upd, mk(8'd3, 1'b0));
        rb = '0;
        step();
        chk_b("t1_empty", upd_valid, 1'b0);

        // Six pushes into a stalled depth-4 queue: two drops, head unchanged
        upd_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rb = mk(8'(10 + i), 1'b0);
            step();
            chk_e("t2_head", upd, mk(8'd10, 1'b0));
            if (i == 2) chk_b("t2_notfull3", full, 1'b0);
            if (i == 3) chk_b("t2_full4", full, 1'b1);
        end
        rb = '0;
        chk_w("t2_drop", drop_cnt, 16'd2);
        chk_b("t2_full", full, 1'b1);

        // Full queue, simultaneous pop and push: accepted, still full, no drop
        rb = mk(8'd16, 1'b0);
        upd_ready = 1'b1;
        step();
        rb = '0;
        chk_b("t3_full", full, 1'b1);
        chk_w("t3_drop", drop_cnt, 16'd2);
        exp_q.push_back(mk(8'd11, 1'b0));
        exp_q.push_back(mk(8'd12, 1'b0));
        exp_q.push_back(mk(8'd13, 1'b0));
        exp_q.push_back(mk(8'd16, 1'b0));
        while (exp_q.size() > 0) begin
            chk_e("t3_drain", upd, exp_q.pop_front());
            step();
        end
        chk_b("t3_empty", upd_valid, 1'b0);
        chk_b("t3_notfull", full, 1'b0);

        // Mispredict opens a squash window until flush; queued entries survive
        upd_ready = 1'b0;
        rb = mk(8'd20, 1'b1);
        step();
        chk_b("t4_squash", dbg_state, 1'b1);
        rb = mk(8'd21, 1'b0);
        step();
        rb = mk(8'd22, 1'b0);
        step();
        rb = '0;
        chk_e("t4_head", upd, mk(8'd20, 1'b1));
        chk_w("t4_drop", drop_cnt, 16'd2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk_b("t4_run", dbg_state, 1'b0);
        rb = mk(8'd23, 1'b0);
        step();
        rb = '0;
        upd_ready = 1'b1;
        exp_q.push_back(mk(8'd20, 1'b1));
        exp_q.push_back(mk(8'd23, 1'b0));
        while (exp_q.size() > 0) begin
            chk_e("t4_drain", upd, exp_q.pop_front());
            step();
        end
        chk_b("t4_empty", upd_valid, 1'b0);

        // Debug mode: plain resolution discarded, mispredict still queued
        upd_ready  = 1'b0;
        debug_mode = 1'b1;
        rb = mk(8'd30, 1'b0);
        step();
        chk_b("t5_discard", upd_valid, 1'b0);
        rb = mk(8'd31, 1'b1);
        step();
        rb = '0;
        chk_e("t5_head", upd, mk(8'd31, 1'b1));
        chk_b("t5_squash", dbg_state, 1'b1);
        chk_w("t5_drop", drop_cnt, 16'd2);
        debug_mode = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk_b("t5_run", dbg_state, 1'b0);
        upd_ready = 1'b1;
        step();
        chk_b("t5_empty", upd_valid, 1'b0);

        // Asynchronous reset with three entries queued and a squash in progress
        upd_ready = 1'b0;
        rb = mk(8'd40, 1'b0);
        step();
        rb = mk(8'd41, 1'b0);
        step();
        rb = mk(8'd42, 1'b1);
        step();
        rb = '0;
        chk_b("t6_pre_valid", upd_valid, 1'b1);
        chk_b("t6_pre_state", dbg_state, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk_b("t6_async_valid", upd_valid, 1'b0);
        chk_b("t6_async_full",  full,      1'b0);
        chk_e("t6_async_upd",   upd,       '0);
        chk_w("t6_async_drop",  drop_cnt,  16'h0);
        chk_b("t6_async_state", dbg_state, 1'b0);
        step();
        step();
        rst = 1'b0;
        step();
        chk_b("t6_post_valid", upd_valid, 1'b0);
        chk_b("t6_post_state", dbg_state, 1'b0);
        upd_ready = 1'b1;
        rb = mk(8'd50, 1'b0);
        step();
        rb = '0;
        chk_e("t6_post_push", upd, mk(8'd50, 1'b0));
        step();
        chk_b("t6_post_empty", upd_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bp_update_sched.md
BP_UPDATE_SCHED -- requirements
Module: bp_update_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries; power of two, at least 2.
REQ-002 SHALL have port clk_i  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset; asynchronous and active-high.
REQ-004 SHALL have port debug_mode_i  input  1  core in debug mode; suppresses predictor training.
REQ-005 SHALL have port flush_i  input  1  frontend redirect done; ends wrong-path squash.
REQ-006 SHALL have port resolved_branch_i  input  bp_resolve_t  resolution from branch unit; .valid qualifies it.
REQ-007 SHALL have port upd_o  output  bp_resolve_t  head entry toward predictor update port.
REQ-008 SHALL have port upd_valid_o  output  1  upd_o holds a valid entry.
REQ-009 SHALL have port upd_ready_i  input  1  predictor accepts upd_o this cycle.
REQ-010 SHALL have port full_o  output  1  queue holds DEPTH entries.
REQ-011 SHALL have port drop_cnt_o  output  16  saturating count of resolutions dropped on overflow.

Function
REQ-012 SHALL keep an in-order FIFO of DEPTH bp_resolve_t entries with read/write pointers wrapping modulo DEPTH and a count of width clog2(DEPTH+1).
REQ-013 SHALL run a two-state FSM, RUN and SQUASH.
REQ-014 In RUN, a valid input SHALL be accepted when there is room, except non-mispredict inputs while debug_mode_i=1, which are discarded and not counted.
REQ-015 There is room when count<DEPTH, or when count==DEPTH and a pop occurs in the same cycle.
REQ-016 A valid, eligible input with no room SHALL be dropped, and drop_cnt_o SHALL increment, saturating at 16'hFFFF.
REQ-017 A mispredict input in debug mode SHALL still be eligible.
REQ-018 Accepting an entry with is_mispredict=1 SHALL move the FSM RUN->SQUASH on the next edge.
REQ-019 In SQUASH, all inputs SHALL be ignored and not counted, because they are wrong-path.
REQ-020 flush_i=1 SHALL move the FSM to RUN on the next edge; an input in that same cycle follows current-state rules.
REQ-021 flush_i SHALL NOT clear the queue; queued entries, including the mispredict, still drain.
REQ-022 flush_i while in RUN SHALL have no effect.
REQ-023 upd_valid_o SHALL equal (count!=0); upd_o SHALL be the head entry with .valid forced to upd_valid_o.
REQ-024 A pop SHALL occur iff upd_valid_o && upd_ready_i.
REQ-025 upd_o SHALL be held stable while upd_valid_o=1 and upd_ready_i=0.
REQ-026 There SHALL be no bypass: an entry accepted in cycle N appears on upd_o no earlier than cycle N+1.
REQ-027 A simultaneous push and pop SHALL leave count unchanged.
REQ-028 full_o SHALL equal (count==DEPTH).
REQ-029 upd_ready_i SHALL be ignored when the queue is empty.

Reset
REQ-030 rst_i=1 SHALL asynchronously clear both pointers, count and drop_cnt_o, and set FSM=RUN.
REQ-031 During and after reset, upd_valid_o=0, full_o=0, drop_cnt_o=0 and upd_o=all zeros.
REQ-032 Reset mid-operation SHALL discard all queued entries, with no partial pop.

Structure
REQ-033 SHALL use bp_resolve_t and cf_t from ariane_pkg.
REQ-034 The FSM state enum SHALL be local to the module.
REQ-035 The queue SHALL be one sub-module, bp_update_fifo, parameterized by DEPTH, with push, pop, full, empty, count and head.

Verification
REQ-036 Push 3 non-mispredict entries, upd_ready_i=1 -> upd_valid_o is 1 from cycle N+1 and entries emerge in order, one per cycle.
REQ-037 DEPTH=4, upd_ready_i=0, push 6 entries -> full_o=1 after 4 pushes, drop_cnt_o=2, upd_o equals the first entry throughout.
REQ-038 Full queue with upd_ready_i=1 and a push in the same cycle -> push accepted, count stays 4, drop_cnt_o unchanged.
REQ-039 Push a mispredict, then 2 pushes, then flush_i, then 1 push -> 2 entries drained (the mispredict, then the post-flush entry); the 2 SQUASH-phase pushes are ignored and not counted.
REQ-040 debug_mode_i=1, push one non-mispredict and one mispredict -> only the mispredict is queued and the FSM enters SQUASH.
REQ-041 Assert rst_i with 3 entries queued and upd_ready_i=0 -> upd_valid_o drops immediately, without waiting for a clock edge; after release the queue is empty and the FSM is in RUN.
